// File: rtl/dcache_flush_seq.sv
// rtl/dcache_flush_seq.sv - write-back-and-invalidate walker over every data cache set
// Optional build macro DCACHE_FLUSH_STATS_EN adds write-back and busy-cycle counters.
module dcache_flush_seq #(
  parameter int SET_ASSOC   = 8,
  parameter int INDEX_W     = 12,
  parameter int BYTE_OFFSET = 4,
  parameter int TAG_W       = 44,
  localparam int ADDR_W     = TAG_W + INDEX_W,
  localparam int WAY_W      = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       flush_i,
  output logic                       flush_ack_o,
  output logic                       busy_o,
  output logic [SET_ASSOC-1:0]       sram_req_o,
  output logic                       sram_we_o,
  output logic [INDEX_W-1:0]         sram_addr_o,
  input  logic                       sram_gnt_i,
  input  logic [SET_ASSOC-1:0]       sram_valid_i,
  input  logic [SET_ASSOC-1:0]       sram_dirty_i,
  input  logic [SET_ASSOC*TAG_W-1:0] sram_tag_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [ADDR_W-1:0]          wb_addr_o,
  output logic [WAY_W-1:0]           wb_way_o
`ifdef DCACHE_FLUSH_STATS_EN
  ,
  output logic [15:0]                wb_count_o,
  output logic [31:0]                cycle_count_o
`endif
);

  localparam int SET_W = INDEX_W - BYTE_OFFSET;

  typedef enum logic [2:0] {IDLE, RD, CHK, WB, CLR, DONE} state_e;

  state_e                     state_q, state_d;
  logic [SET_W-1:0]           index_q;
  logic [SET_ASSOC-1:0]       pend_q;
  logic [SET_ASSOC-1:0]       pend_rest;
  logic [SET_ASSOC*TAG_W-1:0] tag_q;
  logic [WAY_W-1:0]           way_sel;
  logic                       start;
  logic                       last_set;
  logic                       wb_fire;

  assign start     = (state_q == IDLE) && flush_i;
  assign last_set  = &index_q;
  assign wb_fire   = (state_q == WB) && wb_ready_i;
  // pend with its lowest set bit removed: what remains after the current write-back
  assign pend_rest = pend_q & (pend_q - SET_ASSOC'(1));

  always_comb begin
    way_sel = '0;
    for (int i = SET_ASSOC - 1; i >= 0; i--) begin
      if (pend_q[i]) way_sel = WAY_W'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else if (clr_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (flush_i) state_d = RD;
      RD:   if (sram_gnt_i) state_d = CHK;
      CHK:  state_d = (|(sram_valid_i & sram_dirty_i)) ? WB : CLR;
      WB:   if (wb_fire && (pend_rest == '0)) state_d = CLR;
      CLR:  if (sram_gnt_i) state_d = last_set ? DONE : RD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_ack_o = 1'b0;
    sram_req_o  = '0;
    sram_we_o   = 1'b0;
    sram_addr_o = '0;
    wb_valid_o  = 1'b0;
    wb_addr_o   = '0;
    wb_way_o    = '0;
    case (state_q)
      RD: begin
        sram_req_o  = '1;
        sram_addr_o = {index_q, {BYTE_OFFSET{1'b0}}};
      end
      CLR: begin
        sram_req_o  = '1;
        sram_we_o   = 1'b1;
        sram_addr_o = {index_q, {BYTE_OFFSET{1'b0}}};
      end
      WB: begin
        wb_valid_o = 1'b1;
        wb_addr_o  = {tag_q[way_sel*TAG_W +: TAG_W], index_q, {BYTE_OFFSET{1'b0}}};
        wb_way_o   = way_sel;
      end
      DONE: flush_ack_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      index_q <= '0;
      pend_q  <= '0;
      tag_q   <= '0;
    end else if (clr_i) begin
      index_q <= '0;
      pend_q  <= '0;
      tag_q   <= '0;
    end else begin
      if (start) index_q <= '0;
      // the counter never wraps: the last set goes to DONE instead of incrementing
      if ((state_q == CLR) && sram_gnt_i && !last_set) index_q <= index_q + SET_W'(1);
      if (state_q == CHK) begin
        pend_q <= sram_valid_i & sram_dirty_i;
        tag_q  <= sram_tag_i;
      end
      if (wb_fire) pend_q <= pend_rest;
    end
  end

`ifdef DCACHE_FLUSH_STATS_EN
  logic [15:0] wb_cnt_q;
  logic [31:0] cyc_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_cnt_q  <= '0;
      cyc_cnt_q <= '0;
    end else if (clr_i || start) begin
      wb_cnt_q  <= '0;
      cyc_cnt_q <= '0;
    end else begin
      if (wb_fire && (wb_cnt_q != '1)) wb_cnt_q <= wb_cnt_q + 16'd1;
      if (busy_o && (cyc_cnt_q != '1)) cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end

  assign wb_count_o    = wb_cnt_q;
  assign cycle_count_o = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_flush_seq.sv
// tb/tb_dcache_flush_seq.sv - randomized bench: cache image model, SRAM/write-back responder
// Exercises the DCACHE_FLUSH_STATS_EN counters when that macro is defined.
module tb_dcache_flush_seq;
  localparam int NW = 8;
  localparam int TW = 44;
  localparam int NS = 256;

  logic          clk_i = 1'b0;
  logic          rst_ni, clr_i, flush_i;
  logic          flush_ack_o, busy_o;
  logic [NW-1:0] sram_req_o;
  logic          sram_we_o;
  logic [11:0]   sram_addr_o;
  logic          sram_gnt_i;
  logic [NW-1:0] sram_valid_i, sram_dirty_i;
  logic [NW*TW-1:0] sram_tag_i;
  logic          wb_valid_o, wb_ready_i;
  logic [55:0]   wb_addr_o;
  logic [2:0]    wb_way_o;
`ifdef DCACHE_FLUSH_STATS_EN
  logic [15:0]   wb_count_o;
  logic [31:0]   cycle_count_o;
`endif

  dcache_flush_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .flush_i(flush_i),
    .flush_ack_o(flush_ack_o), .busy_o(busy_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_gnt_i(sram_gnt_i), .sram_valid_i(sram_valid_i), .sram_dirty_i(sram_dirty_i),
    .sram_tag_i(sram_tag_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o),
    .wb_way_o(wb_way_o)
`ifdef DCACHE_FLUSH_STATS_EN
    , .wb_count_o(wb_count_o), .cycle_count_o(cycle_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // cache image and expected write-back stream
  logic [NW-1:0] mv [NS];
  logic [NW-1:0] md [NS];
  logic [TW-1:0] mt [NS][NW];
  logic [63:0]   exp_q[$];
  logic [63:0]   wb_log[$];

  int n_vec, n_err;
  int n_clr, n_ack, n_wb, n_stall, exp_clr_set;
  int gnt_pct, ready_pct, stall_left;
  bit stall_arm;
  bit rd_pend, wb_hold, req_hold;
  int rd_set;
  logic [55:0] hold_addr;
  logic [2:0]  hold_way;
  logic [11:0] hold_sram_addr;
  logic        hold_we;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] rtag();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[TW-1:0];
  endfunction

  task automatic fill_image(input int valid_pct, input int dirty_pct);
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = ($urandom_range(99) < valid_pct);
        md[s][w] = ($urandom_range(99) < dirty_pct);
        mt[s][w] = rtag();
      end
    end
  endtask

  // every valid+dirty line in set order, lowest way first within a set
  task automatic build_exp();
    exp_q.delete();
    wb_log.delete();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        if (mv[s][w] && md[s][w])
          exp_q.push_back({5'd0, 3'(w), mt[s][w], 8'(s), 4'h0});
    exp_clr_set = 0;
    n_clr = 0; n_ack = 0; n_wb = 0; n_stall = 0;
  endtask

  // SRAM + write-back responder and per-cycle checks, all on the falling edge
  always @(negedge clk_i) begin
    if (!rst_ni || clr_i) begin
      rd_pend = 0; wb_hold = 0; req_hold = 0;
      sram_gnt_i = 1'b0; wb_ready_i = 1'b0;
    end else begin
      if (wb_hold) begin
        check("wb_hold_valid", wb_valid_o, 1);
        check("wb_hold_addr", wb_addr_o, hold_addr);
        check("wb_hold_way", wb_way_o, hold_way);
      end
      if (req_hold) begin
        check("req_hold", sram_req_o, 8'hFF);
        check("req_hold_addr", sram_addr_o, hold_sram_addr);
        check("req_hold_we", sram_we_o, hold_we);
      end
      if (rd_pend) begin
        sram_valid_i = mv[rd_set];
        sram_dirty_i = md[rd_set];
        for (int w = 0; w < NW; w++) sram_tag_i[w*TW +: TW] = mt[rd_set][w];
      end else begin
        sram_valid_i = NW'($urandom);
        sram_dirty_i = NW'($urandom);
        for (int w = 0; w < NW; w++) sram_tag_i[w*TW +: TW] = rtag();
      end
      rd_pend = 0;
      sram_gnt_i = ($urandom_range(99) < gnt_pct);
      if (stall_arm && wb_valid_o) begin
        stall_arm = 0;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        wb_ready_i = 1'b0;
        stall_left--;
      end else begin
        wb_ready_i = ($urandom_range(99) < ready_pct);
      end
      if (flush_ack_o) n_ack++;
      if ((sram_req_o != '0) && sram_gnt_i) begin
        int s;
        logic [63:0] head;
        bit ok;
        s = int'(sram_addr_o[11:4]);
        if (!sram_we_o) begin
          rd_pend = 1;
          rd_set = s;
        end else begin
          check("clr_order", s, exp_clr_set);
          ok = 1;
          if (exp_q.size() != 0) begin
            head = exp_q[0];
            ok = (int'(head[11:4]) > s);
          end
          check("wb_before_clr", ok, 1);
          mv[s] = '0;
          md[s] = '0;
          exp_clr_set++;
          n_clr++;
        end
      end
      req_hold = (sram_req_o != '0) && !sram_gnt_i;
      hold_sram_addr = sram_addr_o;
      hold_we = sram_we_o;
      if (wb_valid_o && wb_ready_i) begin
        n_wb++;
        wb_log.push_back({5'd0, wb_way_o, wb_addr_o});
        if (exp_q.size() == 0) check("wb_extra", {5'd0, wb_way_o, wb_addr_o}, 64'd0);
        else check("wb_line", {5'd0, wb_way_o, wb_addr_o}, exp_q.pop_front());
      end
      if (wb_valid_o && !wb_ready_i) n_stall++;
      wb_hold = wb_valid_o && !wb_ready_i;
      hold_addr = wb_addr_o;
      hold_way = wb_way_o;
    end
  end

  task automatic run_flush(input int drop_after, output int lat);
    bit seen;
    int nz;
    seen = 0;
    lat = 0;
    flush_i = 1'b1;
    for (int c = 1; c <= 20000 && !seen; c++) begin
      @(posedge clk_i); #1;
      if (c == 1) check("start_index", sram_addr_o, 12'h000);
      if (c == drop_after) flush_i = 1'b0;
      if (flush_ack_o) begin
        seen = 1;
        lat = c;
      end
    end
    check("ack_timeout", seen, 1);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("ack_one_cycle", flush_ack_o, 0);
    check("idle_after_done", busy_o, 0);
    @(posedge clk_i); #1;
    check("no_restart", busy_o, 0);
    check("ack_count", n_ack, 1);
    check("wb_left", exp_q.size(), 0);
    check("sets_cleared", n_clr, NS);
    nz = 0;
    for (int s = 0; s < NS; s++) if (mv[s] != '0 || md[s] != '0) nz++;
    check("image_clear", nz, 0);
  endtask

  task automatic abort_walk(input bit use_clr);
    bit hit;
    hit = 0;
    flush_i = 1'b1;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(posedge clk_i); #1;
      if (sram_req_o != '0 && sram_addr_o[11:4] == 8'd100) hit = 1;
    end
    check("reach_idx100", hit, 1);
    flush_i = 1'b0;
    if (use_clr) clr_i = 1'b1;
    else rst_ni = 1'b0;
    @(posedge clk_i); #1;
    check("abort_busy", busy_o, 0);
    check("abort_req", sram_req_o, 0);
    check("abort_wb", wb_valid_o, 0);
    clr_i = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("abort_no_ack", n_ack, 0);
    check("abort_idle", busy_o, 0);
  endtask

  initial begin
    int lat, nd;
    n_vec = 0; n_err = 0;
    gnt_pct = 100; ready_pct = 100; stall_arm = 0; stall_left = 0;
    rst_ni = 1'b0; clr_i = 1'b0; flush_i = 1'b0;
    sram_gnt_i = 1'b0; wb_ready_i = 1'b0;
    sram_valid_i = '0; sram_dirty_i = '0; sram_tag_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_ack", flush_ack_o, 0);
    check("rst_req", sram_req_o, 0);
    check("rst_we", sram_we_o, 0);
    check("rst_addr", sram_addr_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_addr", wb_addr_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // empty cache, grant always: 256 clears, no write-backs
    fill_image(0, 0);
    build_exp();
    run_flush(0, lat);
    check("clean_latency", lat, 769);
    check("clean_wb", n_wb, 0);
`ifdef DCACHE_FLUSH_STATS_EN
    check("clean_cycles", cycle_count_o, 769);
    check("clean_wb_count", wb_count_o, 0);
`endif

    // set 5: ways 1 and 6 dirty; way 3 valid-clean and way 4 invalid-dirty are skipped
    fill_image(0, 0);
    mv[5] = 8'b0100_1010;
    md[5] = 8'b0101_0010;
    mt[5][1] = 44'hA;
    mt[5][6] = 44'hB;
    build_exp();
    run_flush(0, lat);
    check("set5_wb_n", n_wb, 2);
    if (wb_log.size() >= 2) begin
      check("set5_wb0", wb_log[0], {5'd0, 3'd1, 44'hA, 8'd5, 4'h0});
      check("set5_wb1", wb_log[1], {5'd0, 3'd6, 44'hB, 8'd5, 4'h0});
    end

    // ten-cycle back-pressure on the first write-back
    fill_image(0, 0);
    mv[9] = 8'b0000_0101;
    md[9] = 8'b0000_0101;
    build_exp();
    stall_arm = 1;
    run_flush(0, lat);
    check("stall_cycles", n_stall, 10);
    check("stall_wb_n", n_wb, 2);

    // random grant and ready gaps over random images
    gnt_pct = 40; ready_pct = 50;
    fill_image(60, 40);
    build_exp();
    run_flush(0, lat);
    gnt_pct = 70; ready_pct = 30;
    fill_image(80, 70);
    build_exp();
    run_flush(0, lat);

    // abort at set 100 via reset, then via clear; each restart walks from set 0
    gnt_pct = 100; ready_pct = 100;
    fill_image(50, 30);
    build_exp();
    abort_walk(0);
    fill_image(50, 30);
    build_exp();
    run_flush(0, lat);
    fill_image(50, 30);
    build_exp();
    abort_walk(1);
    fill_image(50, 30);
    build_exp();
    run_flush(0, lat);

    // flush request dropped after two cycles
    gnt_pct = 80; ready_pct = 60;
    fill_image(70, 50);
    build_exp();
    nd = exp_q.size();
    run_flush(2, lat);
    check("drop_wb_n", n_wb, nd);
`ifdef DCACHE_FLUSH_STATS_EN
    check("drop_wb_count", wb_count_o, nd);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
